// File: rtl/ex_mem_skid_reg.sv
// EX->MEM pipeline register with a two-entry skid buffer.
// Every output comes from a flop, so MEM stalls never reach EX through a combinational ready path.
module ex_mem_skid_reg #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CTRL_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_result,
    input  logic [DATA_W-1:0] in_store,
    input  logic [REG_W-1:0]  in_rd,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [4:0]        in_flags,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [DATA_W-1:0] out_store,
    output logic [REG_W-1:0]  out_rd,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [4:0]        out_flags
);

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic [DATA_W-1:0] store;
        logic [REG_W-1:0]  rd;
        logic [CTRL_W-1:0] ctrl;
        logic [4:0]        flags;
    } beat_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state;
    beat_t  main_q;
    beat_t  skid_q;
    beat_t  in_beat;

    assign in_beat = '{result: in_result, store: in_store, rd: in_rd,
                       ctrl: in_ctrl, flags: in_flags};

    // in_ready is only low in FULL, where no input is ever accepted,
    // so in_valid alone stands in for in_xfer in EMPTY and ONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= EMPTY;
            main_q    <= '0;
            skid_q    <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else if (flush) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_valid) begin
                        main_q    <= in_beat;
                        state     <= ONE;
                        out_valid <= 1'b1;
                    end
                end
                ONE: begin
                    if (in_valid && out_ready) begin
                        main_q <= in_beat;
                    end else if (in_valid) begin
                        skid_q   <= in_beat;
                        state    <= FULL;
                        in_ready <= 1'b0;
                    end else if (out_ready) begin
                        state     <= EMPTY;
                        out_valid <= 1'b0;
                    end
                end
                FULL: begin
                    if (out_ready) begin
                        main_q   <= skid_q;
                        state    <= ONE;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign out_result = main_q.result;
    assign out_store  = main_q.store;
    assign out_rd     = main_q.rd;
    assign out_ctrl   = main_q.ctrl;
    assign out_flags  = main_q.flags;

endmodule
